aes_auth_seq: RTL and testbench
===============================

# aes_auth_seq

Sequencer for the AES-128 challenge-response path. It collects a 16-byte challenge from a byte stream and loads it into the AES encryption engine. It launches the engine with a single-cycle start pulse, waits for completion, and streams the 16-byte ciphertext response back out. It sits between the UART byte interface and the AES engine, and is the only block that drives the engine's start and input block.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before declaring an engine fault (range 1..65535; 16-bit counter).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- abort  in  1  synchronous abort; returns to COLLECT from any state.
- in_data  in  8  challenge byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- out_data  out  8  response byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- aes_block  out  128  plaintext to engine, held stable from LAUNCH through WAIT.
- aes_start  out  1  one-cycle start pulse to engine.
- aes_done  in  1  engine completion pulse.
- aes_result  in  128  engine ciphertext, sampled on aes_done.
- busy  out  1  high in LAUNCH, WAIT, SEND.
- error  out  1  one-cycle pulse on timeout.

## Operation
- All outputs are registered. Reset values: in_ready=1, out_valid=0, out_data=0, aes_block=0, aes_start=0, busy=0, error=0. State resets to COLLECT with the byte counter at 0.
- States: COLLECT, LAUNCH, WAIT, SEND.
- COLLECT: in_ready=1. On each in_valid&&in_ready, shift the byte into aes_block from the top: the first byte lands in [127:120] and the 16th in [7:0]. A 4-bit counter increments per byte. When the 16th byte is accepted, go to LAUNCH and drop in_ready.
- LAUNCH: assert aes_start for exactly one cycle, then go to WAIT.
- WAIT: the timeout counter increments each cycle. On aes_done, capture aes_result into the response shift register and go to SEND.
- SEND: out_valid=1 and out_data = response[127:120]. On out_valid&&out_ready, shift left by 8 and increment the byte counter. After the 16th transfer, out_valid drops and the state returns to COLLECT with in_ready=1.
- aes_done outside WAIT is ignored. This includes a done arriving in the same cycle as aes_start.
- abort takes priority over every other event in the same cycle. Its effects: next state COLLECT, counters cleared, out_valid=0, aes_start=0. aes_block is retained but overwritten by the next collection. A late aes_done after an abort is ignored.
- Reset asserted mid-operation returns to reset values immediately. No partial response is ever emitted.

## Timing
- A byte accepted on cycle N: if it is the 16th, LAUNCH occurs on N+1 and aes_start is high on cycle N+1.
- aes_done high on cycle M: out_valid is high on M+1 with out_data = aes_result[127:120].
- Both streams sustain 1 byte/cycle. Minimum turnaround is 16 in + 1 LAUNCH + engine latency + 1 + 16 out cycles.
- out_data and out_valid hold stable while out_valid && !out_ready.
- in_ready may drop in the cycle after the 16th acceptance. Upstream must honour valid/ready; no byte is lost or duplicated.

## Configuration
- AES_AUTH_TIMEOUT_EN defined: the WAIT timeout is active. When the counter reaches TIMEOUT_CYCLES without aes_done, error pulses for one cycle, the state returns to COLLECT with counters cleared, and no response is sent.
- AES_AUTH_TIMEOUT_EN undefined: no timeout counter is built. WAIT persists until aes_done or abort, and error is tied to 0.

## Test plan
- FIPS-197 C.1 vector: stream bytes 00 11 22 … ff with the engine keyed 000102…0f. The bench must see aes_block=00112233445566778899aabbccddeeff and one aes_start pulse. The response bytes must be 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in order, after which in_ready=1.
- Backpressure: hold out_ready low for 5 cycles at byte 3 of the response. out_data must hold 0xd8 throughout and the complete 16-byte response must be unchanged. Drive in_valid with random gaps as well; aes_block must be identical.
- Timeout (AES_AUTH_TIMEOUT_EN, TIMEOUT_CYCLES=20): the engine stub never asserts done. error must pulse exactly once, 20 cycles after entering WAIT. No out_valid may occur, and the next challenge must complete normally.
- Abort in SEND after 7 bytes: out_valid must be low the next cycle and in_ready=1. A new challenge must then yield a full 16-byte response.
- Spurious aes_done during COLLECT and in the cycle of aes_start: the pulse must be ignored and the response taken from the real done.
- rst_n pulsed low mid-WAIT: all outputs must return to reset values asynchronously, and a later engine done must not produce output.

Source files
------------

// File: rtl/aes_auth_seq.sv
// aes_auth_seq: AES-128 challenge-response sequencer.
// Collects a 16-byte challenge from a byte stream into aes_block (first byte
// in [127:120]), issues a one-cycle aes_start, waits for aes_done, then
// streams the captured 16-byte ciphertext out MSB-byte first.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   abort                synchronous abort back to COLLECT
//   in_data/in_valid/in_ready     challenge byte stream (valid/ready)
//   out_data/out_valid/out_ready  response byte stream (valid/ready)
//   aes_block, aes_start          plaintext and start pulse to the engine
//   aes_done, aes_result          engine completion pulse and ciphertext
//   busy                 high in LAUNCH, WAIT, SEND
//   error                one-cycle pulse on engine timeout
//
// Parameter TIMEOUT_CYCLES (1..65535): WAIT cycles before an engine fault.
// Optional feature macro: AES_AUTH_TIMEOUT_EN enables the WAIT timeout;
// when undefined no timeout counter exists and error stays 0.
module aes_auth_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] aes_block,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  output logic         busy,
  output logic         error
);

  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, SEND} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] resp;
`ifdef AES_AUTH_TIMEOUT_EN
  logic [15:0]  tcnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      resp      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      aes_block <= '0;
      aes_start <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
`ifdef AES_AUTH_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      // Pulse outputs default low; only the branches below raise them.
      aes_start <= 1'b0;
      error     <= 1'b0;
      if (abort) begin
        state     <= COLLECT;
        cnt       <= '0;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
        busy      <= 1'b0;
`ifdef AES_AUTH_TIMEOUT_EN
        tcnt      <= '0;
`endif
      end else begin
        case (state)
          COLLECT: begin
            if (in_valid && in_ready) begin
              aes_block <= {aes_block[119:0], in_data};
              cnt       <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                state     <= LAUNCH;
                in_ready  <= 1'b0;
                aes_start <= 1'b1;
                busy      <= 1'b1;
              end
            end
          end
          LAUNCH: begin
            // A done seen here coincides with aes_start and is ignored.
            state <= WAIT;
`ifdef AES_AUTH_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
          WAIT: begin
            if (aes_done) begin
              resp      <= aes_result;
              out_data  <= aes_result[127:120];
              out_valid <= 1'b1;
              cnt       <= '0;
              state     <= SEND;
            end
`ifdef AES_AUTH_TIMEOUT_EN
            else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
              error    <= 1'b1;
              state    <= COLLECT;
              cnt      <= '0;
              tcnt     <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
`endif
          end
          SEND: begin
            if (out_valid && out_ready) begin
              resp     <= {resp[119:0], 8'h00};
              out_data <= resp[119:112];
              cnt      <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                out_valid <= 1'b0;
                state     <= COLLECT;
                in_ready  <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_auth_seq.sv
// tb_aes_auth_seq: directed self-checking bench for aes_auth_seq with a
// behavioural engine stub (configurable latency, can be muted).
module tb_aes_auth_seq;
  localparam int unsigned TO = 20;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] aes_block;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_result;
  logic         busy;
  logic         error;

  always #5 clk = ~clk;

  aes_auth_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .aes_block(aes_block), .aes_start(aes_start),
    .aes_done(aes_done), .aes_result(aes_result),
    .busy(busy), .error(error)
  );

  int cmp_n = 0;
  int fail_n = 0;

  // Engine stub: the FIPS-197 C.1 pair, otherwise an arbitrary fixed mapping.
  function automatic logic [127:0] eng_model(input logic [127:0] b);
    if (b == FIPS_PT) return FIPS_CT;
    return {b[63:0] ^ 64'h0123456789abcdef, ~b[127:64]};
  endfunction

  logic         eng_mute = 1'b0;
  int           eng_lat = 4;
  int           eng_cnt = 0;
  logic         eng_done = 1'b0;
  logic [127:0] eng_result = '0;
  logic         spur_done = 1'b0;
  int           start_cnt = 0;
  int           err_cnt = 0;

  assign aes_done   = eng_done | spur_done;
  assign aes_result = spur_done ? 128'hbadbadbadbadbadbadbadbadbadbad00 : eng_result;

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
    if (aes_start === 1'b1) begin
      start_cnt = start_cnt + 1;
      if (!eng_mute) begin
        eng_cnt    = eng_lat;
        eng_result = eng_model(aes_block);
      end
    end
    if (error === 1'b1) err_cnt = err_cnt + 1;
  end

  // Streams 16 bytes; returns at the negedge of the cycle after the 16th
  // acceptance. spur_at >= 0 raises a spurious done while byte spur_at is due.
  task automatic send_challenge(input logic [127:0] blk, input int gap_pct, input int spur_at);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 2000) begin
      @(negedge clk);
      guard++;
      spur_done = (spur_at >= 0 && i == spur_at);
      if (in_ready === 1'b1 && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = blk[127-8*i -: 8];
        i++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    spur_done = 1'b0;
    cmp_n++;
    if (guard >= 2000) begin
      fail_n++;
      $display("FAIL send_timeout: bytes sent %0d, required 16", i);
    end
  endtask

  task automatic recv_response(input logic [127:0] exp, input int stall_at, input int stall_len,
                               input int abort_at, output logic [127:0] got, output int n);
    int stall;
    int guard;
    stall = stall_len;
    guard = 0;
    n = 0;
    got = '0;
    while (n < 16 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (abort_at >= 0 && n == abort_at) begin
        out_ready = 1'b0;
        abort = 1'b1;
        break;
      end
      if (out_valid === 1'b1) begin
        if (n == stall_at && stall > 0) begin
          out_ready = 1'b0;
          stall--;
          cmp_n++;
          if (out_data !== exp[127-8*n -: 8]) begin
            fail_n++;
            $display("FAIL stall_hold: out_data %h, required %h", out_data, exp[127-8*n -: 8]);
          end
        end else begin
          out_ready = 1'b1;
          got[127-8*n -: 8] = out_data;
          n++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    abort = 1'b0;
    if (guard >= 500) begin
      cmp_n++;
      fail_n++;
      $display("FAIL recv_timeout: bytes received %0d", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp_n++; if (in_ready !== 1'b1) begin fail_n++; $display("FAIL rst_in_ready: %b, required 1", in_ready); end
    cmp_n++; if (out_valid !== 1'b0) begin fail_n++; $display("FAIL rst_out_valid: %b, required 0", out_valid); end
    cmp_n++; if (out_data !== 8'h00) begin fail_n++; $display("FAIL rst_out_data: %h, required 00", out_data); end
    cmp_n++; if (aes_block !== 128'h0) begin fail_n++; $display("FAIL rst_aes_block: %h, required 0", aes_block); end
    cmp_n++; if (aes_start !== 1'b0) begin fail_n++; $display("FAIL rst_aes_start: %b, required 0", aes_start); end
    cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("FAIL rst_busy: %b, required 0", busy); end
    cmp_n++; if (error !== 1'b0) begin fail_n++; $display("FAIL rst_error: %b, required 0", error); end
  endtask

  task automatic test_fips();
    int s0;
    int k;
    int n;
    logic [127:0] got;
    eng_lat = 4;
    s0 = start_cnt;
    send_challenge(FIPS_PT, 0, -1);
    cmp_n++; if (aes_start !== 1'b1) begin fail_n++; $display("FAIL fips_start: %b, required 1", aes_start); end
    cmp_n++; if (in_ready !== 1'b0) begin fail_n++; $display("FAIL fips_in_ready_drop: %b, required 0", in_ready); end
    cmp_n++; if (busy !== 1'b1) begin fail_n++; $display("FAIL fips_busy: %b, required 1", busy); end
    cmp_n++; if (aes_block !== FIPS_PT) begin fail_n++; $display("FAIL fips_block: %h, required %h", aes_block, FIPS_PT); end
    @(negedge clk);
    cmp_n++; if (aes_start !== 1'b0) begin fail_n++; $display("FAIL fips_start_width: %b, required 0", aes_start); end
    k = 0;
    do begin @(posedge clk); k++; end while (aes_done !== 1'b1 && k < 50);
    @(negedge clk);
    cmp_n++; if (out_valid !== 1'b1 || out_data !== 8'h69) begin
      fail_n++; $display("FAIL fips_first_byte: valid %b data %h, required 1 69", out_valid, out_data);
    end
    recv_response(FIPS_CT, -1, 0, -1, got, n);
    cmp_n++; if (got !== FIPS_CT) begin fail_n++; $display("FAIL fips_response: %h, required %h", got, FIPS_CT); end
    cmp_n++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fail_n++; $display("FAIL fips_end: valid %b ready %b busy %b, required 0 1 0", out_valid, in_ready, busy);
    end
    cmp_n++; if (start_cnt - s0 != 1) begin fail_n++; $display("FAIL fips_start_count: %0d, required 1", start_cnt - s0); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] got;
    eng_lat = 5;
    send_challenge(FIPS_PT, 40, -1);
    cmp_n++; if (aes_block !== FIPS_PT) begin fail_n++; $display("FAIL bp_block: %h, required %h", aes_block, FIPS_PT); end
    recv_response(FIPS_CT, 3, 5, -1, got, n);
    cmp_n++; if (got !== FIPS_CT) begin fail_n++; $display("FAIL bp_response: %h, required %h", got, FIPS_CT); end
    cmp_n++; if (aes_block !== FIPS_PT) begin fail_n++; $display("FAIL bp_block_held: %h, required %h", aes_block, FIPS_PT); end
  endtask

  task automatic test_timeout();
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] got;
    int n;
    int k;
    int e0;
    logic saw_ov;
    blk_a = 128'hfedcba9876543210f0e1d2c3b4a59687;
    blk_b = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    eng_mute = 1'b1;
    e0 = err_cnt;
    saw_ov = 1'b0;
    send_challenge(blk_a, 0, -1);
    k = 0;
`ifdef AES_AUTH_TIMEOUT_EN
    do begin
      @(negedge clk); k++;
      if (out_valid === 1'b1) saw_ov = 1'b1;
    end while (error !== 1'b1 && k < 100);
    cmp_n++; if (k != 21) begin fail_n++; $display("FAIL to_latency: %0d cycles after start, required 21", k); end
    repeat (4) @(negedge clk);
    #1;
    cmp_n++; if (err_cnt - e0 != 1) begin fail_n++; $display("FAIL to_error_pulses: %0d, required 1", err_cnt - e0); end
    cmp_n++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fail_n++; $display("FAIL to_recover: ready %b busy %b, required 1 0", in_ready, busy);
    end
`else
    repeat (40) begin
      @(negedge clk); k++;
      if (out_valid === 1'b1) saw_ov = 1'b1;
    end
    #1;
    cmp_n++; if (err_cnt != e0 || busy !== 1'b1) begin
      fail_n++; $display("FAIL nto_wait: errors %0d busy %b, required 0 1", err_cnt - e0, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cmp_n++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fail_n++; $display("FAIL nto_abort: ready %b busy %b, required 1 0", in_ready, busy);
    end
`endif
    cmp_n++; if (saw_ov !== 1'b0) begin fail_n++; $display("FAIL to_no_output: saw out_valid %b, required 0", saw_ov); end
    eng_mute = 1'b0;
    eng_lat = 3;
    send_challenge(blk_b, 0, -1);
    recv_response(eng_model(blk_b), -1, 0, -1, got, n);
    cmp_n++; if (got !== eng_model(blk_b)) begin
      fail_n++; $display("FAIL to_next_response: %h, required %h", got, eng_model(blk_b));
    end
  endtask

  task automatic test_abort();
    logic [127:0] blk_c;
    logic [127:0] blk_d;
    logic [127:0] got;
    int n;
    blk_c = 128'h3141592653589793238462643383279f;
    blk_d = 128'h2718281828459045235360287471352a;
    eng_lat = 3;
    send_challenge(blk_c, 0, -1);
    recv_response(eng_model(blk_c), -1, 0, 7, got, n);
    cmp_n++; if (n != 7) begin fail_n++; $display("FAIL abort_bytes: %0d, required 7", n); end
    cmp_n++; if (got[127:72] !== eng_model(blk_c) >> 72) begin
      fail_n++; $display("FAIL abort_partial: %h, required %h", got[127:72], eng_model(blk_c) >> 72);
    end
    cmp_n++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fail_n++; $display("FAIL abort_state: valid %b ready %b busy %b, required 0 1 0", out_valid, in_ready, busy);
    end
    send_challenge(blk_d, 10, -1);
    recv_response(eng_model(blk_d), -1, 0, -1, got, n);
    cmp_n++; if (got !== eng_model(blk_d)) begin
      fail_n++; $display("FAIL abort_next_response: %h, required %h", got, eng_model(blk_d));
    end
  endtask

  task automatic test_spurious();
    logic [127:0] blk_e;
    logic [127:0] got;
    int n;
    blk_e = 128'hc0ffee00deadbeef0123456789abcdef;
    eng_lat = 6;
    send_challenge(blk_e, 20, 5);
    spur_done = 1'b1;          // overlaps the LAUNCH cycle, alongside aes_start
    @(negedge clk);
    spur_done = 1'b0;
    cmp_n++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fail_n++; $display("FAIL spur_ignored: busy %b valid %b, required 1 0", busy, out_valid);
    end
    cmp_n++; if (aes_block !== blk_e) begin fail_n++; $display("FAIL spur_block: %h, required %h", aes_block, blk_e); end
    recv_response(eng_model(blk_e), -1, 0, -1, got, n);
    cmp_n++; if (got !== eng_model(blk_e)) begin
      fail_n++; $display("FAIL spur_response: %h, required %h", got, eng_model(blk_e));
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [127:0] blk_f;
    logic saw_ov;
    blk_f = 128'h55aa55aa0102030405060708090a0b0c;
    eng_lat = 30;
    send_challenge(blk_f, 0, -1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp_n++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
      fail_n++; $display("FAIL rmw_ctrl: ready %b valid %b data %h busy %b, required 1 0 00 0",
                         in_ready, out_valid, out_data, busy);
    end
    cmp_n++; if (aes_block !== 128'h0 || aes_start !== 1'b0 || error !== 1'b0) begin
      fail_n++; $display("FAIL rmw_engine_if: block %h start %b error %b, required 0 0 0", aes_block, aes_start, error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_ov = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_ov = 1'b1;
    end
    cmp_n++; if (saw_ov !== 1'b0 || busy !== 1'b0) begin
      fail_n++; $display("FAIL rmw_late_done: saw valid %b busy %b, required 0 0", saw_ov, busy);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_timeout();
    test_abort();
    test_spurious();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
